// File: rtl/rs_arb_pkg.sv
// Shared types and sizing helpers for the RS-encoder line arbiter.
//   arb_state_e : input-side FSM states (IDLE bubble / LOCKED on one block)
//   id_w()      : $clog2 with a floor of 1, for ids and beat counters
package rs_arb_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rs_arb_tag_fifo.sv
// In-order FIFO of source ids, one entry per codeword block in flight
// through the encoder. The head names the destination of the block
// currently leaving the encoder.
//   clk, rst    : clock, async active-high reset (pointers and count only)
//   push_i/din_i: enqueue a source id (never asserted while full)
//   pop_i       : dequeue the head (never asserted while empty)
//   head_o      : oldest id
//   full_o      : DEPTH entries held
//   empty_o     : no entries held
// Push and pop in the same cycle are both honoured; occupancy is unchanged.
module rs_arb_tag_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic         full_o,
   output logic         empty_o
);
   import rs_arb_pkg::*;

   localparam int AW = id_w(DEPTH);
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;

   // Explicit wrap keeps non-power-of-2 and DEPTH=1 correct.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_i) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= din_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/rs_encode_line_arb.sv
// Shares one RS line encoder among NUM_SRC line streams. A source is
// granted a whole codeword block (NUM_LINES lines) round-robin; its id is
// queued in a tag FIFO so the encoder's {line, parity} beats are steered
// back to the matching destination in order.
//   clk, rst                : clock, async active-high reset
//   src_arb_line_val/_line  : per-source line stream (source i at [i*DATA_W +: DATA_W])
//   arb_src_line_rdy        : per-source ready (only the granted source)
//   arb_encoder_line_val/_line, encoder_arb_line_rdy : to encoder input
//   encoder_arb_line_val/_data, arb_encoder_line_rdy : from encoder output
//   arb_dst_line_val/arb_dst_data, dst_arb_line_rdy  : per-destination output
// Both paths are combinational muxes; only control state is registered.
module rs_encode_line_arb
   import rs_arb_pkg::*;
#(
   parameter int NUM_SRC   = 4,
   parameter int DATA_W    = 512,
   parameter int PARITY_W  = 256,
   parameter int NUM_LINES = 4,
   parameter int TAG_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_SRC-1:0]            src_arb_line_val,
   input  logic [NUM_SRC*DATA_W-1:0]     src_arb_line,
   output logic [NUM_SRC-1:0]            arb_src_line_rdy,
   output logic                          arb_encoder_line_val,
   output logic [DATA_W-1:0]             arb_encoder_line,
   input  logic                          encoder_arb_line_rdy,
   input  logic                          encoder_arb_line_val,
   input  logic [DATA_W+PARITY_W-1:0]    encoder_arb_data,
   output logic                          arb_encoder_line_rdy,
   output logic [NUM_SRC-1:0]            arb_dst_line_val,
   output logic [DATA_W+PARITY_W-1:0]    arb_dst_data,
   input  logic [NUM_SRC-1:0]            dst_arb_line_rdy
);

   localparam int SRC_ID_W = id_w(NUM_SRC);
   localparam int CNT_W    = id_w(NUM_LINES);
   localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(NUM_LINES - 1);
   localparam logic [SRC_ID_W-1:0] LAST_SRC = SRC_ID_W'(NUM_SRC - 1);

   arb_state_e          state_q, state_d;
   logic [SRC_ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [SRC_ID_W-1:0] grant_q, grant_d;
   logic [CNT_W-1:0]    in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;

   logic                pick_vld;
   logic [SRC_ID_W-1:0] pick_id;
   logic                tag_push, tag_pop;
   logic                fifo_full, fifo_empty;
   logic [SRC_ID_W-1:0] head_id;
   logic                in_hs, in_last, out_hs;

   // Round-robin pick: first valid source at or after rr_ptr, wrapping.
   // Scan offsets high to low so the smallest offset wins.
   always_comb begin
      logic [SRC_ID_W:0]   sum;
      logic [SRC_ID_W-1:0] idx;
      sum      = '0;
      idx      = '0;
      pick_vld = 1'b0;
      pick_id  = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         sum = {1'b0, rr_ptr_q} + (SRC_ID_W+1)'(k);
         if (sum >= (SRC_ID_W+1)'(NUM_SRC)) sum = sum - (SRC_ID_W+1)'(NUM_SRC);
         idx = sum[SRC_ID_W-1:0];
         if (src_arb_line_val[idx]) begin
            pick_vld = 1'b1;
            pick_id  = idx;
         end
      end
   end

   // ---- input FSM: state register ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ARB_IDLE;
      else     state_q <= state_d;
   end

   // ---- input FSM: next state ----
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE:   if (pick_vld && !fifo_full) state_d = ARB_LOCKED;
         ARB_LOCKED: if (in_last)                state_d = ARB_IDLE;
         default:    state_d = ARB_IDLE;
      endcase
   end

   // ---- input FSM: outputs ----
   // IDLE is a deliberate bubble: no handshake while the grant is chosen.
   always_comb begin
      arb_encoder_line_val = 1'b0;
      arb_src_line_rdy     = '0;
      tag_push             = 1'b0;
      case (state_q)
         ARB_IDLE:   tag_push = pick_vld && !fifo_full;
         ARB_LOCKED: begin
            arb_encoder_line_val      = src_arb_line_val[grant_q];
            arb_src_line_rdy[grant_q] = encoder_arb_line_rdy;
         end
         default: ;
      endcase
   end

   always_comb begin
      arb_encoder_line = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant_q == SRC_ID_W'(i)) arb_encoder_line = src_arb_line[i*DATA_W +: DATA_W];
      end
   end

   assign in_hs   = arb_encoder_line_val && encoder_arb_line_rdy;
   assign in_last = in_hs && (in_cnt_q == LAST_CNT);

   // Grant, input beat count and rr pointer advance.
   always_comb begin
      grant_d  = grant_q;
      in_cnt_d = in_cnt_q;
      rr_ptr_d = rr_ptr_q;
      if (tag_push) begin
         grant_d  = pick_id;
         in_cnt_d = '0;
      end else if (in_hs) begin
         in_cnt_d = in_last ? '0 : in_cnt_q + CNT_W'(1);
         if (in_last) rr_ptr_d = (grant_q == LAST_SRC) ? '0 : grant_q + SRC_ID_W'(1);
      end
   end

   // ---- output side: steer encoder beats by tag FIFO head ----
   always_comb begin
      arb_dst_line_val     = '0;
      arb_encoder_line_rdy = 1'b0;
      if (!fifo_empty) begin
         arb_dst_line_val[head_id] = encoder_arb_line_val;
         arb_encoder_line_rdy      = dst_arb_line_rdy[head_id];
      end
   end

   assign arb_dst_data = encoder_arb_data;
   assign out_hs       = encoder_arb_line_val && arb_encoder_line_rdy;
   assign tag_pop      = out_hs && (out_cnt_q == LAST_CNT);

   always_comb begin
      out_cnt_d = out_cnt_q;
      if (out_hs) out_cnt_d = tag_pop ? '0 : out_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q  <= '0;
         grant_q   <= '0;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         grant_q   <= grant_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
      end
   end

   rs_arb_tag_fifo #(
      .DEPTH (TAG_DEPTH),
      .W     (SRC_ID_W)
   ) u_tag_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (tag_push),
      .din_i   (pick_id),
      .pop_i   (tag_pop),
      .head_o  (head_id),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule

// File: tb/tb_rs_encode_line_arb.sv
// Bench for rs_encode_line_arb: queue-based sources, a 3-cycle in-order
// encoder pipe, credit-limited destinations, and a round-robin block-order
// model computed from per-source block counts.
module tb_rs_encode_line_arb;

   localparam int NS  = 4;
   localparam int DW  = 16;
   localparam int PW  = 8;
   localparam int NL  = 4;
   localparam int TD  = 4;
   localparam int OW  = DW + PW;
   localparam int BIG = 1000000;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [NS-1:0]  src_arb_line_val = '0;
   logic [NS*DW-1:0] src_arb_line = '0;
   logic [NS-1:0]  arb_src_line_rdy;
   logic           arb_encoder_line_val;
   logic [DW-1:0]  arb_encoder_line;
   logic           encoder_arb_line_rdy = 1'b0;
   logic           encoder_arb_line_val = 1'b0;
   logic [OW-1:0]  encoder_arb_data = '0;
   logic           arb_encoder_line_rdy;
   logic [NS-1:0]  arb_dst_line_val;
   logic [OW-1:0]  arb_dst_data;
   logic [NS-1:0]  dst_arb_line_rdy = '0;

   always #5 clk = ~clk;

   rs_encode_line_arb #(
      .NUM_SRC(NS), .DATA_W(DW), .PARITY_W(PW), .NUM_LINES(NL), .TAG_DEPTH(TD)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .src_arb_line_val     (src_arb_line_val),
      .src_arb_line         (src_arb_line),
      .arb_src_line_rdy     (arb_src_line_rdy),
      .arb_encoder_line_val (arb_encoder_line_val),
      .arb_encoder_line     (arb_encoder_line),
      .encoder_arb_line_rdy (encoder_arb_line_rdy),
      .encoder_arb_line_val (encoder_arb_line_val),
      .encoder_arb_data     (encoder_arb_data),
      .arb_encoder_line_rdy (arb_encoder_line_rdy),
      .arb_dst_line_val     (arb_dst_line_val),
      .arb_dst_data         (arb_dst_data),
      .dst_arb_line_rdy     (dst_arb_line_rdy)
   );

   typedef struct packed {
      logic [DW-1:0] d;
      int            c;
   } enc_t;

   logic [DW-1:0] src_q   [NS][$];
   logic [OW-1:0] exp_q   [NS][$];
   logic [OW-1:0] dst_got [NS][$];
   int   src_sent [NS];
   int   src_limit[NS];
   int   credit   [NS];
   enc_t enc_q[$];
   int   in_log[$], in_cyc[$], out_cyc[$];
   int   cyc = 0;
   bit   rand_bp = 1'b0;
   int   err_line = 0, err_bus = 0, err_hot = 0;
   int   n_chk = 0, n_pass = 0;
   int   hs_src, hs_dst;
   enc_t et;

   function automatic logic [OW-1:0] enc_word(input logic [DW-1:0] d);
      return {d, d[PW-1:0] ^ d[DW-1:DW-PW] ^ 8'h5A};
   endfunction

   function automatic bit busy();
      bit b = (enc_q.size() != 0);
      for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) b = 1'b1;
      return b;
   endfunction

   // Sources, encoder pipe and destinations. Inputs change on the falling
   // edge; handshakes for the coming rising edge are decided 1 ns later.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         for (int i = 0; i < NS; i++) begin
            src_q[i].delete(); exp_q[i].delete(); dst_got[i].delete();
            src_sent[i] = 0;
         end
         enc_q.delete(); in_log.delete(); in_cyc.delete(); out_cyc.delete();
         src_arb_line_val = '0; src_arb_line = '0;
         encoder_arb_line_rdy = 1'b0; encoder_arb_line_val = 1'b0;
         encoder_arb_data = '0; dst_arb_line_rdy = '0;
      end else begin
         for (int i = 0; i < NS; i++) begin
            src_arb_line_val[i] = (src_q[i].size() > 0) && (src_sent[i] < src_limit[i]);
            src_arb_line[i*DW +: DW] = src_arb_line_val[i] ? src_q[i][0] : '0;
            dst_arb_line_rdy[i] = (credit[i] > 0) && (!rand_bp || $urandom_range(0, 2) != 0);
         end
         encoder_arb_line_rdy = (enc_q.size() < 32) && (!rand_bp || $urandom_range(0, 3) != 0);
         if (enc_q.size() > 0 && enc_q[0].c + 3 <= cyc) begin
            encoder_arb_line_val = 1'b1;
            encoder_arb_data     = enc_word(enc_q[0].d);
         end else begin
            encoder_arb_line_val = 1'b0;
            encoder_arb_data     = '0;
         end
         #1;
         if ($countones(arb_src_line_rdy) > 1 || $countones(arb_dst_line_val) > 1) err_hot++;
         if (|arb_dst_line_val && arb_dst_data !== encoder_arb_data) err_bus++;
         if (encoder_arb_line_val && arb_encoder_line_rdy) begin
            hs_dst = -1;
            for (int k = 0; k < NS; k++) if (arb_dst_line_val[k] && dst_arb_line_rdy[k]) hs_dst = k;
            if (hs_dst < 0) err_hot++;
            else begin
               dst_got[hs_dst].push_back(arb_dst_data);
               credit[hs_dst]--;
               out_cyc.push_back(cyc);
            end
            void'(enc_q.pop_front());
         end else if (|(arb_dst_line_val & dst_arb_line_rdy)) err_hot++;
         if (arb_encoder_line_val && encoder_arb_line_rdy) begin
            hs_src = -1;
            for (int k = 0; k < NS; k++) if (arb_src_line_rdy[k]) hs_src = k;
            if (hs_src < 0 || !src_arb_line_val[hs_src] || src_q[hs_src].size() == 0) err_hot++;
            else begin
               if (arb_encoder_line !== src_q[hs_src][0]) err_line++;
               void'(src_q[hs_src].pop_front());
               src_sent[hs_src]++;
               in_log.push_back(hs_src);
               in_cyc.push_back(cyc);
               et.d = arb_encoder_line; et.c = cyc;
               enc_q.push_back(et);
            end
         end else if (|(arb_src_line_rdy & src_arb_line_val)) err_hot++;
      end
   end

   task automatic sync();
      @(negedge clk); #2;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   task automatic open_all();
      rand_bp = 1'b0;
      for (int i = 0; i < NS; i++) begin credit[i] = BIG; src_limit[i] = BIG; end
   endtask

   task automatic do_reset();
      sync(); rst = 1'b1;
      wait_cyc(2); rst = 1'b0;
      open_all();
   endtask

   task automatic load(input int s, input int n, input logic [DW-1:0] base, input bit rnd);
      logic [DW-1:0] d;
      for (int k = 0; k < n; k++) begin
         d = rnd ? DW'($urandom) : base + DW'(k);
         src_q[s].push_back(d);
         exp_q[s].push_back(enc_word(d));
      end
   endtask

   task automatic wait_drain(input string nm, input int maxc);
      int c = 0;
      while (busy() && c < maxc) begin @(negedge clk); c++; end
      wait_cyc(3);
      n_chk++;
      if (busy()) $display("FAIL %s drain: still busy after %0d cycles, required idle", nm, maxc);
      else n_pass++;
   endtask

   // Expected block grant order: repeatedly take the first source with
   // blocks left at or after the pointer, then move the pointer past it.
   task automatic rr_model(input int cnt_in[NS], output int ord[$]);
      int cnt[NS];
      int ptr = 0, tot = 0, s;
      cnt = cnt_in;
      ord.delete();
      for (int i = 0; i < NS; i++) tot += cnt[i];
      while (tot > 0) begin
         for (int k = 0; k < NS; k++) begin
            s = (ptr + k) % NS;
            if (cnt[s] > 0) begin
               ord.push_back(s); cnt[s]--; tot--; ptr = (s + 1) % NS;
               break;
            end
         end
      end
   endtask

   task automatic test_reset();
      wait_cyc(3);
      n_chk++; if (arb_src_line_rdy !== '0) $display("FAIL rst_src_rdy: got %b want 0", arb_src_line_rdy); else n_pass++;
      n_chk++; if (arb_encoder_line_val !== 1'b0) $display("FAIL rst_enc_val: got %b want 0", arb_encoder_line_val); else n_pass++;
      n_chk++; if (arb_encoder_line_rdy !== 1'b0) $display("FAIL rst_enc_rdy: got %b want 0", arb_encoder_line_rdy); else n_pass++;
      n_chk++; if (arb_dst_line_val !== '0) $display("FAIL rst_dst_val: got %b want 0", arb_dst_line_val); else n_pass++;
      rst = 1'b0;
      open_all();
      wait_cyc(3);
      n_chk++; if (arb_encoder_line_val !== 1'b0) $display("FAIL post_rst_enc_val: got %b want 0", arb_encoder_line_val); else n_pass++;
      n_chk++; if (arb_encoder_line_rdy !== 1'b0) $display("FAIL post_rst_enc_rdy: got %b want 0", arb_encoder_line_rdy); else n_pass++;
   endtask

   task automatic test_single();
      int c0;
      do_reset();
      c0 = cyc;
      load(2, 4, 16'h00A0, 1'b0);
      wait_drain("single", 200);
      n_chk++; if (in_cyc.size() != 4 || in_cyc[0] != c0 + 2)
         $display("FAIL single_first_beat: got cycle %0d want %0d", in_cyc[0], c0 + 2); else n_pass++;
      n_chk++; if (in_cyc[3] != c0 + 5)
         $display("FAIL single_last_beat: got cycle %0d want %0d", in_cyc[3], c0 + 5); else n_pass++;
      for (int d = 0; d < NS; d++) begin
         bit ok = (dst_got[d].size() == exp_q[d].size());
         for (int k = 0; ok && k < dst_got[d].size(); k++) if (dst_got[d][k] !== exp_q[d][k]) ok = 1'b0;
         n_chk++;
         if (!ok) $display("FAIL single_dst%0d: got %0d beats want %0d (or data differs)", d, dst_got[d].size(), exp_q[d].size());
         else n_pass++;
      end
      n_chk++; if (arb_encoder_line_rdy !== 1'b0 || arb_dst_line_val !== '0)
         $display("FAIL single_fifo_empty: rdy %b dst_val %b want 0", arb_encoder_line_rdy, arb_dst_line_val); else n_pass++;
   endtask

   task automatic check_order_data(input string nm, input int cnt[NS]);
      int  ord[$];
      bit  ok;
      rr_model(cnt, ord);
      ok = (in_log.size() == NL * ord.size());
      for (int b = 0; ok && b < ord.size(); b++)
         for (int j = 0; j < NL; j++) if (in_log[NL*b + j] != ord[b]) ok = 1'b0;
      n_chk++;
      if (!ok) $display("FAIL %s_order: got %0d beats first src %0d, want %0d blocks first src %0d",
                        nm, in_log.size(), in_log[0], ord.size(), ord[0]);
      else n_pass++;
      for (int d = 0; d < NS; d++) begin
         ok = (dst_got[d].size() == exp_q[d].size());
         for (int k = 0; ok && k < dst_got[d].size(); k++) if (dst_got[d][k] !== exp_q[d][k]) ok = 1'b0;
         n_chk++;
         if (!ok) $display("FAIL %s_dst%0d: got %0d beats want %0d (or data differs)", nm, d, dst_got[d].size(), exp_q[d].size());
         else n_pass++;
      end
   endtask

   task automatic test_rr();
      int cnt[NS] = '{2, 2, 2, 2};
      do_reset();
      for (int s = 0; s < NS; s++) load(s, 8, DW'(16'h1000 * (s + 1)), 1'b0);
      wait_drain("rr", 500);
      check_order_data("rr", cnt);
   endtask

   task automatic test_fifo_full();
      int cnt[NS] = '{2, 1, 1, 1};
      do_reset();
      for (int i = 0; i < NS; i++) credit[i] = 0;
      load(0, 8, 16'h2000, 1'b0);
      for (int s = 1; s < NS; s++) load(s, 4, DW'(16'h2000 + 16'h100 * s), 1'b0);
      wait_cyc(60);
      n_chk++; if (in_log.size() != 16) $display("FAIL full_stall: got %0d beats want 16", in_log.size()); else n_pass++;
      n_chk++; if (arb_encoder_line_val !== 1'b0) $display("FAIL full_idle: enc val %b want 0", arb_encoder_line_val); else n_pass++;
      for (int i = 0; i < NS; i++) credit[i] = BIG;
      wait_drain("full", 500);
      n_chk++; if (in_cyc[16] != out_cyc[3] + 2)
         $display("FAIL full_resume: got cycle %0d want %0d", in_cyc[16], out_cyc[3] + 2); else n_pass++;
      check_order_data("full", cnt);
   endtask

   task automatic test_stall();
      int cnt[NS] = '{0, 1, 0, 1};
      do_reset();
      src_limit[1] = 2;
      load(1, 4, 16'h3100, 1'b0);
      load(3, 4, 16'h3300, 1'b0);
      wait_cyc(15);
      n_chk++; if (in_log.size() != 2) $display("FAIL stall_hold: got %0d beats want 2", in_log.size()); else n_pass++;
      src_limit[1] = BIG;
      wait_drain("stall", 200);
      check_order_data("stall", cnt);
   endtask

   task automatic test_reset_mid();
      int cnt[NS] = '{1, 0, 0, 1};
      do_reset();
      for (int i = 0; i < NS; i++) credit[i] = 0;
      src_limit[1] = 2;
      load(0, 4, 16'h4000, 1'b0);
      load(1, 4, 16'h4100, 1'b0);
      wait_cyc(20);
      n_chk++; if (in_log.size() != 6) $display("FAIL midrst_setup: got %0d beats want 6", in_log.size()); else n_pass++;
      sync(); rst = 1'b1; #1;
      n_chk++; if (arb_src_line_rdy !== '0) $display("FAIL midrst_src_rdy: got %b want 0", arb_src_line_rdy); else n_pass++;
      n_chk++; if (arb_encoder_line_val !== 1'b0) $display("FAIL midrst_enc_val: got %b want 0", arb_encoder_line_val); else n_pass++;
      n_chk++; if (arb_encoder_line_rdy !== 1'b0) $display("FAIL midrst_enc_rdy: got %b want 0", arb_encoder_line_rdy); else n_pass++;
      n_chk++; if (arb_dst_line_val !== '0) $display("FAIL midrst_dst_val: got %b want 0", arb_dst_line_val); else n_pass++;
      wait_cyc(2); rst = 1'b0;
      open_all();
      load(0, 4, 16'h00B0, 1'b0);
      load(3, 4, 16'h00C0, 1'b0);
      wait_drain("midrst", 200);
      check_order_data("midrst", cnt);
   endtask

   task automatic test_push_pop();
      int cnt[NS] = '{2, 2, 1, 1};
      do_reset();
      for (int i = 0; i < NS; i++) credit[i] = 0;
      src_limit[3] = 0;
      for (int s = 0; s < NS; s++) load(s, 4, DW'(16'h5000 + 16'h100 * s), 1'b0);
      wait_cyc(40);
      n_chk++; if (in_log.size() != 12) $display("FAIL pp_setup: got %0d beats want 12", in_log.size()); else n_pass++;
      credit[0] = 3;
      wait_cyc(15);
      n_chk++; if (dst_got[0].size() != 3) $display("FAIL pp_three_out: got %0d beats want 3", dst_got[0].size()); else n_pass++;
      credit[0] = 1; src_limit[3] = BIG;
      wait_cyc(10);
      n_chk++; if (in_cyc[12] != out_cyc[3] + 1)
         $display("FAIL pp_coincide: got cycle %0d want %0d", in_cyc[12], out_cyc[3] + 1); else n_pass++;
      wait_cyc(30);
      n_chk++; if (in_log.size() != 16) $display("FAIL pp_block3: got %0d beats want 16", in_log.size()); else n_pass++;
      load(0, 4, 16'h5800, 1'b0);
      load(1, 4, 16'h5900, 1'b0);
      wait_cyc(30);
      n_chk++; if (in_log.size() != 20 || in_log[16] != 0)
         $display("FAIL pp_occupancy: got %0d beats src %0d want 20 src 0", in_log.size(), in_log[16]); else n_pass++;
      for (int i = 0; i < NS; i++) credit[i] = BIG;
      wait_drain("pp", 500);
      check_order_data("pp", cnt);
   endtask

   task automatic test_random();
      int cnt[NS];
      for (int it = 0; it < 3; it++) begin
         do_reset();
         rand_bp = 1'b1;
         for (int s = 0; s < NS; s++) begin
            cnt[s] = $urandom_range(0, 3);
            load(s, NL * cnt[s], '0, 1'b1);
         end
         wait_drain("rand", 3000);
         check_order_data("rand", cnt);
      end
   endtask

   task automatic test_protocol();
      n_chk++; if (err_line != 0) $display("FAIL enc_line_mux: got %0d bad beats want 0", err_line); else n_pass++;
      n_chk++; if (err_bus != 0) $display("FAIL dst_data_bus: got %0d bad beats want 0", err_bus); else n_pass++;
      n_chk++; if (err_hot != 0) $display("FAIL handshake_onehot: got %0d violations want 0", err_hot); else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < NS; i++) begin credit[i] = 0; src_limit[i] = BIG; src_sent[i] = 0; end
      test_reset();
      test_single();
      test_rr();
      test_fifo_full();
      test_stall();
      test_reset_mid();
      test_push_pop();
      test_random();
      test_protocol();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
